censor_word_tokenizer: RTL and testbench

- Sits directly upstream of the 8-bit Pearson hasher in the censor_stream IP.
- Accepts the incoming text byte stream (AXI-Stream style) and splits it into words.
- Drives the hasher's enable/init/char interface, one byte per word character.
- At each word end, emits a word record (hash, length, start offset, flags) for the downstream banned-word matcher.

---
 rtl/censor_word_tokenizer_if.sv | 34 +++
 rtl/censor_word_tokenizer.sv | 161 ++++++++++++++++
 tb/tb_censor_word_tokenizer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/censor_word_tokenizer_if.sv
// Bundle of the tokenizer's byte-stream input, hasher drive/feedback and word-record output.
// The slave modport is the tokenizer's view; master is the surrounding environment.
interface censor_word_tokenizer_if #(
  parameter int LEN_W  = 6,
  parameter int OFFS_W = 12
);
  logic [7:0]        s_tdata;
  logic              s_tvalid;
  logic              s_tlast;
  logic              s_tready;
  logic              hash_en;
  logic              hash_init;
  logic [7:0]        hash_char;
  logic [7:0]        hash_in;
  logic              m_valid;
  logic              m_ready;
  logic [7:0]        m_hash;
  logic [LEN_W-1:0]  m_len;
  logic [OFFS_W-1:0] m_start;
  logic              m_long;
  logic              m_last;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, hash_in, m_ready,
    output s_tready, hash_en, hash_init, hash_char,
           m_valid, m_hash, m_len, m_start, m_long, m_last
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, hash_in, m_ready,
    input  s_tready, hash_en, hash_init, hash_char,
           m_valid, m_hash, m_len, m_start, m_long, m_last
  );
endinterface

// File: rtl/censor_word_tokenizer.sv
// Splits a byte stream into words, feeds word characters to an external Pearson hasher
// and emits one record (hash, length, start offset, flags) per word or end-of-packet marker.
module censor_word_tokenizer #(
  parameter int LEN_W          = 6,
  parameter int OFFS_W         = 12,
  parameter int CASE_FOLD      = 1,
  parameter int DIGITS_IN_WORD = 0
) (
  input logic                   clock,
  input logic                   reset_n,
  censor_word_tokenizer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WORD, EMIT} state_t;

  localparam logic [LEN_W-1:0]  LEN_MAX  = '1;
  localparam logic [OFFS_W-1:0] OFFS_MAX = '1;

  state_t            state, state_next;
  logic [LEN_W-1:0]  len_q;
  logic [OFFS_W-1:0] start_q;
  logic [OFFS_W-1:0] offset_q;
  logic              long_q;
  logic              last_q;
  logic              ready;
  logic              acc;
  logic              word_char;
  logic [7:0]        folded;
  logic              hash_en;
  logic              hash_init;
  logic [7:0]        hash_char;

  function automatic logic is_word_char(input logic [7:0] c);
    logic r;
    r = (c >= 8'h61 && c <= 8'h7A) || (c >= 8'h41 && c <= 8'h5A);
    if (DIGITS_IN_WORD != 0 && c >= 8'h30 && c <= 8'h39)
      r = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] fold_char(input logic [7:0] c);
    if (CASE_FOLD != 0 && c >= 8'h41 && c <= 8'h5A)
      return c | 8'h20;
    return c;
  endfunction

  assign ready     = reset_n && (state != EMIT);
  assign acc       = bus.s_tvalid && ready;
  assign word_char = is_word_char(bus.s_tdata);
  assign folded    = fold_char(bus.s_tdata);

  always_comb begin
    state_next = state;
    hash_en    = 1'b0;
    hash_init  = 1'b0;
    hash_char  = 8'h00;
    case (state)
      IDLE: begin
        if (acc && word_char) begin
          hash_en    = 1'b1;
          hash_char  = folded;
          state_next = bus.s_tlast ? EMIT : WORD;
        end else begin
          // Keep the hasher pinned at zero between words.
          hash_en   = 1'b1;
          hash_init = 1'b1;
          if (acc && bus.s_tlast)
            state_next = EMIT;
        end
      end
      WORD: begin
        if (acc) begin
          if (word_char) begin
            hash_en   = 1'b1;
            hash_char = folded;
            if (bus.s_tlast)
              state_next = EMIT;
          end else begin
            state_next = EMIT;
          end
        end
      end
      EMIT: begin
        if (bus.m_ready) begin
          hash_en    = 1'b1;
          hash_init  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (!reset_n) begin
      hash_en   = 1'b1;
      hash_init = 1'b1;
      hash_char = 8'h00;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      len_q    <= '0;
      start_q  <= '0;
      offset_q <= '0;
      long_q   <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state <= state_next;
      if (acc) begin
        if (bus.s_tlast)
          offset_q <= '0;
        else if (offset_q != OFFS_MAX)
          offset_q <= offset_q + 1'b1;
      end
      case (state)
        IDLE: begin
          if (acc && word_char) begin
            len_q   <= {{(LEN_W-1){1'b0}}, 1'b1};
            start_q <= offset_q;
            long_q  <= 1'b0;
            last_q  <= bus.s_tlast;
          end else if (acc && bus.s_tlast) begin
            len_q   <= '0;
            start_q <= offset_q;
            long_q  <= 1'b0;
            last_q  <= 1'b1;
          end
        end
        WORD: begin
          if (acc) begin
            if (word_char) begin
              if (len_q == LEN_MAX)
                long_q <= 1'b1;
              else
                len_q <= len_q + 1'b1;
            end
            last_q <= bus.s_tlast;
          end
        end
        EMIT: begin
          if (bus.m_ready) begin
            len_q  <= '0;
            long_q <= 1'b0;
            last_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.s_tready  = ready;
  assign bus.hash_en   = hash_en;
  assign bus.hash_init = hash_init;
  assign bus.hash_char = hash_char;
  assign bus.m_valid   = (state == EMIT);
  assign bus.m_hash    = bus.hash_in;
  assign bus.m_len     = len_q;
  assign bus.m_start   = start_q;
  assign bus.m_long    = long_q;
  assign bus.m_last    = last_q;
endmodule

// File: tb/tb_censor_word_tokenizer.sv
// Directed bench for censor_word_tokenizer with a behavioural Pearson hasher in the loop.
module tb_censor_word_tokenizer;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  censor_word_tokenizer_if #(.LEN_W(6), .OFFS_W(12)) bus ();

  censor_word_tokenizer #(
    .LEN_W(6), .OFFS_W(12), .CASE_FOLD(1), .DIGITS_IN_WORD(0)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Pearson table: an odd-multiplier permutation with two entries swapped so that
  // hash("a") = 0x5D and hash("ab") = T[0x5D ^ 0x62] = T[0x3F] = 0x0E.
  logic [7:0] tbl [256];
  logic [7:0] hstate;

  always @(posedge clock)
    if (bus.hash_en)
      hstate <= bus.hash_init ? 8'h00 : tbl[hstate ^ bus.hash_char];
  assign bus.hash_in = hstate;

  task automatic fix_entry(input int idx, input logic [7:0] val);
    logic [7:0] tmp;
    for (int j = 0; j < 256; j++) begin
      if (tbl[j] == val) begin
        tmp      = tbl[idx];
        tbl[idx] = val;
        tbl[j]   = tmp;
        break;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    int n = 0;
    @(negedge clock);
    bus.s_tdata  = b;
    bus.s_tvalid = 1'b1;
    bus.s_tlast  = last;
    while (bus.s_tready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("send_ready", {31'd0, bus.s_tready}, 32'd1);
    @(posedge clock);
    #1;
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
  endtask

  task automatic get_record(input string tag, input logic [7:0] e_hash, input int e_len,
                            input int e_start, input logic chk_start,
                            input logic e_long, input logic e_last);
    int n = 0;
    while (bus.m_valid !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_valid"}, {31'd0, bus.m_valid}, 32'd1);
    check({tag, "_hash"}, {24'd0, bus.m_hash}, {24'd0, e_hash});
    check({tag, "_len"}, {26'd0, bus.m_len}, e_len);
    if (chk_start)
      check({tag, "_start"}, {20'd0, bus.m_start}, e_start);
    check({tag, "_long"}, {31'd0, bus.m_long}, {31'd0, e_long});
    check({tag, "_last"}, {31'd0, bus.m_last}, {31'd0, e_last});
    bus.m_ready = 1'b1;
    @(posedge clock);
    #1;
    bus.m_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_h;
    logic [7:0] ch;

    for (int i = 0; i < 256; i++)
      tbl[i] = 8'((i * 167) + 13);
    fix_entry(8'h61, 8'h5D);
    fix_entry(8'h3F, 8'h0E);

    bus.s_tdata  = 8'h00;
    bus.s_tvalid = 1'b0;
    bus.s_tlast  = 1'b0;
    bus.m_ready  = 1'b0;

    // Reset behaviour
    #1;
    check("rst_tready", {31'd0, bus.s_tready}, 32'd0);
    check("rst_hash_en", {31'd0, bus.hash_en}, 32'd1);
    check("rst_hash_init", {31'd0, bus.hash_init}, 32'd1);
    check("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("post_rst_len", {26'd0, bus.m_len}, 32'd0);
    check("post_rst_start", {20'd0, bus.m_start}, 32'd0);
    check("post_rst_long", {31'd0, bus.m_long}, 32'd0);
    check("post_rst_last", {31'd0, bus.m_last}, 32'd0);
    check("post_rst_tready", {31'd0, bus.s_tready}, 32'd1);
    check("post_rst_hash", {24'd0, bus.m_hash}, 32'd0);

    // "a " : single-letter word, record appears right after the space
    send(8'h61, 1'b0);
    check("t1_pre_valid", {31'd0, bus.m_valid}, 32'd0);
    send(8'h20, 1'b0);
    check("t1_rise", {31'd0, bus.m_valid}, 32'd1);
    get_record("t1", 8'h5D, 1, 0, 1'b1, 1'b0, 1'b0);
    send(8'h2E, 1'b1);
    get_record("t1_marker", 8'h00, 0, 0, 1'b0, 1'b0, 1'b1);

    // "Ab" closing the packet, then "c." starting again at offset 0
    send(8'h41, 1'b0);
    send(8'h62, 1'b1);
    get_record("t2", 8'h0E, 2, 0, 1'b1, 1'b0, 1'b1);
    send(8'h63, 1'b0);
    send(8'h2E, 1'b1);
    get_record("t2_next", tbl[8'h63], 1, 0, 1'b1, 1'b0, 1'b1);

    // " ab." with downstream stalled for 5 cycles
    send(8'h20, 1'b0);
    send(8'h61, 1'b0);
    send(8'h62, 1'b0);
    send(8'h2E, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t3_tready", {31'd0, bus.s_tready}, 32'd0);
      check("t3_valid", {31'd0, bus.m_valid}, 32'd1);
      check("t3_hash", {24'd0, bus.m_hash}, 32'h0E);
      check("t3_len", {26'd0, bus.m_len}, 32'd2);
      check("t3_start", {20'd0, bus.m_start}, 32'd1);
    end
    get_record("t3", 8'h0E, 2, 1, 1'b1, 1'b0, 1'b1);
    repeat (3) begin
      @(negedge clock);
      check("t3_no_marker", {31'd0, bus.m_valid}, 32'd0);
    end

    // "  ." : delimiter-only packet yields one marker record
    send(8'h20, 1'b0);
    send(8'h20, 1'b0);
    check("t4_no_early", {31'd0, bus.m_valid}, 32'd0);
    send(8'h2E, 1'b1);
    get_record("t4", 8'h00, 0, 0, 1'b0, 1'b0, 1'b1);
    repeat (2) begin
      @(negedge clock);
      check("t4_single", {31'd0, bus.m_valid}, 32'd0);
    end

    // 70-letter word with mixed case: length saturates at 63, long flag set
    exp_h = 8'h00;
    for (int i = 0; i < 70; i++) begin
      ch = (i % 3 == 0) ? 8'(8'h41 + (i % 26)) : 8'(8'h61 + (i % 26));
      send(ch, 1'b0);
      exp_h = tbl[exp_h ^ 8'(8'h61 + (i % 26))];
    end
    send(8'h20, 1'b0);
    get_record("t5", exp_h, 63, 0, 1'b1, 1'b1, 1'b0);
    send(8'h2E, 1'b1);
    get_record("t5_marker", 8'h00, 0, 0, 1'b0, 1'b0, 1'b1);

    // "x9y" : digits are delimiters here
    send(8'h78, 1'b0);
    send(8'h39, 1'b0);
    get_record("t6_x", tbl[8'h78], 1, 0, 1'b1, 1'b0, 1'b0);
    send(8'h79, 1'b1);
    get_record("t6_y", tbl[8'h79], 1, 2, 1'b1, 1'b0, 1'b1);

    // Reset in the middle of "hello", then "a "
    send(8'h68, 1'b0);
    send(8'h65, 1'b0);
    @(negedge clock);
    bus.s_tdata  = 8'h6C;
    bus.s_tvalid = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    check("t7_rst_tready", {31'd0, bus.s_tready}, 32'd0);
    check("t7_rst_valid", {31'd0, bus.m_valid}, 32'd0);
    check("t7_rst_hash_en", {31'd0, bus.hash_en}, 32'd1);
    check("t7_rst_hash_init", {31'd0, bus.hash_init}, 32'd1);
    @(posedge clock);
    #1;
    check("t7_rst_valid2", {31'd0, bus.m_valid}, 32'd0);
    @(negedge clock);
    bus.s_tvalid = 1'b0;
    reset_n = 1'b1;
    send(8'h61, 1'b0);
    send(8'h20, 1'b0);
    get_record("t7", 8'h5D, 1, 0, 1'b1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
